// File: rtl/hdmi_pkg.sv
// Shared HDMI constants: TMDS period encoding, preamble/guard/island lengths and CTL codes.
package hdmi_pkg;

  localparam logic [2:0] PER_CTRL    = 3'd0;
  localparam logic [2:0] PER_VID_PRE = 3'd1;
  localparam logic [2:0] PER_VID_GB  = 3'd2;
  localparam logic [2:0] PER_VIDEO   = 3'd3;
  localparam logic [2:0] PER_DI_PRE  = 3'd4;
  localparam logic [2:0] PER_DI_GB   = 3'd5;
  localparam logic [2:0] PER_DI_DATA = 3'd6;

  localparam int PRE_LEN     = 8;
  localparam int GB_LEN      = 2;
  localparam int DATA_LEN    = 32;
  localparam int ISLAND_LEN  = 44;
  localparam int MIN_CTL_GAP = 12;

  localparam logic [3:0] CTL_NONE    = 4'b0000;
  localparam logic [3:0] CTL_VID_PRE = 4'b1000;
  localparam logic [3:0] CTL_DI_PRE  = 4'b1010;

  typedef enum logic [2:0] {
    S_CTRL, S_DI_PRE, S_DI_GB_LEAD, S_DI_DATA, S_DI_GB_TRAIL, S_VID_PRE, S_VID_GB, S_VIDEO
  } state_e;

endpackage

// File: rtl/hdmi_period_scheduler.sv
// Schedules HDMI control, video and data-island periods per pixel; all outputs are
// registered one clock after the counterX/counterY/sync inputs they describe.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int ISLAND_X = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] counterX,
  input  logic [10:0] counterY,
  input  logic        hSync_in,
  input  logic        vSync_in,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  output logic        pkt_rd,
  output logic [4:0]  pkt_idx,
  input  logic        pkt_hdr_bit,
  input  logic [3:0]  pkt_ch1,
  input  logic [3:0]  pkt_ch2,
  output logic [2:0]  period,
  output logic [3:0]  ctl,
  output logic        VDE,
  output logic        ADE,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  aux_data_0,
  output logic [3:0]  aux_data_1,
  output logic [3:0]  aux_data_2
);

  localparam logic [10:0] X_VID_START = 11'(H_TOTAL - 10);
  localparam logic [10:0] X_VID_END   = 11'(H_ACTIVE);
  localparam logic [10:0] X_ISL_START = 11'(H_ACTIVE + ISLAND_X);
  localparam logic [10:0] Y_ACTIVE    = 11'(V_ACTIVE);
  localparam logic [10:0] Y_LAST      = 11'(V_TOTAL - 1);
  localparam logic [5:0]  PH_PRE_END  = 6'(PRE_LEN - 1);
  localparam logic [5:0]  PH_GB_END   = 6'(GB_LEN - 1);
  localparam logic [5:0]  PH_DATA_END = 6'(DATA_LEN - 1);

  if (H_ACTIVE + ISLAND_X + ISLAND_LEN + MIN_CTL_GAP > H_TOTAL - 10) begin : g_gap_check
    $error("data island leaves less than the minimum control gap before the video preamble");
  end

  state_e      state_q, state_d;
  logic [5:0]  phase_q, phase_d;
  logic [2:0]  period_q, period_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        vde_q, vde_d, ade_q, ade_d;
  logic        hsync_q, vsync_q;
  logic        pkt_ready_q, pkt_ready_d, pkt_rd_q, pkt_rd_d;
  logic [4:0]  pkt_idx_q, pkt_idx_d;
  logic [3:0]  aux0_q, aux0_d, aux1_q, aux1_d, aux2_q, aux2_d;
  logic [10:0] y_next;
  logic        video_line;

  assign y_next     = counterY + 11'd1;
  assign video_line = (y_next < Y_ACTIVE) || (counterY == Y_LAST);

  // state_d/phase_d describe the pixel currently on counterX, given the previous pixel's state.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 6'd1;
    case (state_q)
      S_CTRL: begin
        phase_d = '0;
        if (video_line && counterX == X_VID_START) state_d = S_VID_PRE;
        else if (pkt_valid && counterX == X_ISL_START) state_d = S_DI_PRE;
      end
      S_DI_PRE:      if (phase_q == PH_PRE_END)  begin state_d = S_DI_GB_LEAD;  phase_d = '0; end
      S_DI_GB_LEAD:  if (phase_q == PH_GB_END)   begin state_d = S_DI_DATA;     phase_d = '0; end
      S_DI_DATA:     if (phase_q == PH_DATA_END) begin state_d = S_DI_GB_TRAIL; phase_d = '0; end
      S_DI_GB_TRAIL: if (phase_q == PH_GB_END)   begin state_d = S_CTRL;        phase_d = '0; end
      S_VID_PRE:     if (phase_q == PH_PRE_END)  begin state_d = S_VID_GB;      phase_d = '0; end
      S_VID_GB:      if (phase_q == PH_GB_END)   begin state_d = S_VIDEO;       phase_d = '0; end
      S_VIDEO: begin
        phase_d = '0;
        if (counterX == X_VID_END) state_d = S_CTRL;
      end
      default: begin state_d = S_CTRL; phase_d = '0; end
    endcase
  end

  // pkt_rd/pkt_idx run one pixel ahead so the payload returned in that cycle is
  // captured into aux_data alongside the DI_DATA period it belongs to.
  always_comb begin
    period_d    = PER_CTRL;
    ctl_d       = CTL_NONE;
    vde_d       = 1'b0;
    ade_d       = 1'b0;
    pkt_ready_d = (state_q == S_CTRL) && (state_d == S_DI_PRE);
    pkt_rd_d    = 1'b0;
    pkt_idx_d   = '0;
    aux0_d      = '0;
    aux1_d      = '0;
    aux2_d      = '0;
    case (state_d)
      S_DI_PRE: begin
        period_d = PER_DI_PRE;
        ctl_d    = CTL_DI_PRE;
      end
      S_DI_GB_LEAD, S_DI_GB_TRAIL: begin
        period_d = PER_DI_GB;
        ade_d    = 1'b1;
        aux0_d   = {2'b11, vSync_in, hSync_in};
        if (state_d == S_DI_GB_LEAD && phase_d == PH_GB_END) pkt_rd_d = 1'b1;
      end
      S_DI_DATA: begin
        period_d = PER_DI_DATA;
        ade_d    = 1'b1;
        aux0_d   = {(phase_d[4:0] != 5'd0), pkt_hdr_bit, vSync_in, hSync_in};
        aux1_d   = pkt_ch1;
        aux2_d   = pkt_ch2;
        if (phase_d != PH_DATA_END) begin
          pkt_rd_d  = 1'b1;
          pkt_idx_d = phase_d[4:0] + 5'd1;
        end
      end
      S_VID_PRE: begin
        period_d = PER_VID_PRE;
        ctl_d    = CTL_VID_PRE;
      end
      S_VID_GB: period_d = PER_VID_GB;
      S_VIDEO: begin
        period_d = PER_VIDEO;
        vde_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CTRL;
      phase_q     <= '0;
      period_q    <= PER_CTRL;
      ctl_q       <= CTL_NONE;
      vde_q       <= 1'b0;
      ade_q       <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      pkt_ready_q <= 1'b0;
      pkt_rd_q    <= 1'b0;
      pkt_idx_q   <= '0;
      aux0_q      <= '0;
      aux1_q      <= '0;
      aux2_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      period_q    <= period_d;
      ctl_q       <= ctl_d;
      vde_q       <= vde_d;
      ade_q       <= ade_d;
      hsync_q     <= hSync_in;
      vsync_q     <= vSync_in;
      pkt_ready_q <= pkt_ready_d;
      pkt_rd_q    <= pkt_rd_d;
      pkt_idx_q   <= pkt_idx_d;
      aux0_q      <= aux0_d;
      aux1_q      <= aux1_d;
      aux2_q      <= aux2_d;
    end
  end

  assign period     = period_q;
  assign ctl        = ctl_q;
  assign VDE        = vde_q;
  assign ADE        = ade_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign pkt_ready  = pkt_ready_q;
  assign pkt_rd     = pkt_rd_q;
  assign pkt_idx    = pkt_idx_q;
  assign aux_data_0 = aux0_q;
  assign aux_data_1 = aux1_q;
  assign aux_data_2 = aux2_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: a pixel-by-pixel reference model built from
// line/offset arithmetic, driven by a timing generator with randomized payload and syncs.
module tb_hdmi_period_scheduler;

  localparam int H_ACTIVE = 640, H_TOTAL = 800, V_ACTIVE = 480, V_TOTAL = 525, ISLAND_X = 4;
  localparam int ISL_X0 = H_ACTIVE + ISLAND_X;
  localparam int VP_X0  = H_TOTAL - 10;
  localparam logic [2:0] P_CTRL = 3'd0, P_VID_PRE = 3'd1, P_VID_GB = 3'd2, P_VIDEO = 3'd3,
                         P_DI_PRE = 3'd4, P_DI_GB = 3'd5, P_DI_DATA = 3'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [10:0] counterX = '0, counterY = '0;
  logic        hSync_in = 1'b0, vSync_in = 1'b0, pkt_valid = 1'b0;
  logic        pkt_ready, pkt_rd, pkt_hdr_bit;
  logic [4:0]  pkt_idx;
  logic [3:0]  pkt_ch1, pkt_ch2, ctl, aux_data_0, aux_data_1, aux_data_2;
  logic [2:0]  period;
  logic        VDE, ADE, hSync, vSync;

  logic [31:0] hdr_mem;
  logic [3:0]  ch1_mem [32];
  logic [3:0]  ch2_mem [32];

  // Packet source: answers the read strobe combinationally.
  assign pkt_hdr_bit = pkt_rd ? hdr_mem[pkt_idx] : 1'b0;
  assign pkt_ch1     = pkt_rd ? ch1_mem[pkt_idx] : 4'h0;
  assign pkt_ch2     = pkt_rd ? ch2_mem[pkt_idx] : 4'h0;

  hdmi_period_scheduler #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .ISLAND_X(ISLAND_X)
  ) dut (
    .clk(clk), .reset(reset), .counterX(counterX), .counterY(counterY),
    .hSync_in(hSync_in), .vSync_in(vSync_in), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_rd(pkt_rd), .pkt_idx(pkt_idx),
    .pkt_hdr_bit(pkt_hdr_bit), .pkt_ch1(pkt_ch1), .pkt_ch2(pkt_ch2),
    .period(period), .ctl(ctl), .VDE(VDE), .ADE(ADE), .hSync(hSync), .vSync(vSync),
    .aux_data_0(aux_data_0), .aux_data_1(aux_data_1), .aux_data_2(aux_data_2)
  );

  int checks = 0, failures = 0, nprint = 0;
  int cx, cy;
  int isl_base = -1, vpre_base = -1;
  bit vid_on = 1'b0;
  logic [24:0] exp_v, obs_v;
  logic [4:0]  exp_idx, obs_idx;
  bit          exp_rd;

  function automatic bit vidline(input int y);
    return (y + 1 < V_ACTIVE) || (y == V_TOTAL - 1);
  endfunction

  function automatic int nx();
    return (cx == H_TOTAL - 1) ? 0 : cx + 1;
  endfunction

  function automatic logic hs_of(input int x);
    return (x >= 656 && x < 752);
  endfunction

  function automatic logic vs_of(input int y);
    return (y >= 490 && y < 492);
  endfunction

  task automatic new_payload();
    hdr_mem = $urandom;
    for (int i = 0; i < 32; i++) begin
      ch1_mem[i] = 4'($urandom);
      ch2_mem[i] = 4'($urandom);
    end
  endtask

  task automatic goto(input int x, input int y);
    cx = x - 1;
    cy = y;
  endtask

  // Advance one pixel, predict that pixel's outputs, clock it and capture the DUT outputs.
  task automatic step(input logic hs, input logic vs, input logic pv, input logic rst);
    int o, di;
    logic [2:0] per;
    logic [3:0] a0, a1, a2, ectl;
    logic rdy;
    if (cx == H_TOTAL - 1) begin
      cx = 0;
      cy = (cy == V_TOTAL - 1) ? 0 : cy + 1;
    end else cx++;
    counterX = 11'(cx); counterY = 11'(cy);
    hSync_in = hs; vSync_in = vs; pkt_valid = pv; reset = rst;
    per = P_CTRL; rdy = 1'b0; a0 = '0; a1 = '0; a2 = '0; exp_rd = 1'b0; exp_idx = '0;
    if (rst) begin
      isl_base = -1; vpre_base = -1; vid_on = 1'b0;
    end else begin
      if (isl_base >= 0 && (cx < isl_base || cx - isl_base >= 44)) isl_base = -1;
      if (vid_on && cx >= H_ACTIVE) vid_on = 1'b0;
      if (vpre_base >= 0 && cx < vpre_base) begin vpre_base = -1; vid_on = 1'b1; end
      if (isl_base < 0 && vpre_base < 0 && !vid_on && pv && cx == ISL_X0) begin
        isl_base = cx; rdy = 1'b1;
      end
      if (isl_base < 0 && vpre_base < 0 && !vid_on && cx == VP_X0 && vidline(cy)) vpre_base = cx;
      if (isl_base >= 0) begin
        o = cx - isl_base;
        if (o < 8) per = P_DI_PRE;
        else if (o < 10 || o >= 42) begin per = P_DI_GB; a0 = {2'b11, vs, hs}; end
        else begin
          di = o - 10;
          per = P_DI_DATA;
          a0 = {(di != 0), hdr_mem[di], vs, hs};
          a1 = ch1_mem[di];
          a2 = ch2_mem[di];
        end
        if (o + 1 >= 10 && o + 1 < 42) begin exp_rd = 1'b1; exp_idx = 5'(o + 1 - 10); end
      end else if (vpre_base >= 0) per = (cx - vpre_base < 8) ? P_VID_PRE : P_VID_GB;
      else if (vid_on) per = P_VIDEO;
    end
    ectl = (per == P_VID_PRE) ? 4'b1000 : (per == P_DI_PRE) ? 4'b1010 : 4'b0000;
    exp_v = {per, ectl, per == P_VIDEO, (per == P_DI_GB) || (per == P_DI_DATA),
             rst ? 1'b0 : hs, rst ? 1'b0 : vs, rdy, exp_rd, a0, a1, a2};
    @(posedge clk);
    #1;
    obs_v   = {period, ctl, VDE, ADE, hSync, vSync, pkt_ready, pkt_rd, aux_data_0, aux_data_1, aux_data_2};
    obs_idx = exp_rd ? pkt_idx : 5'd0;
  endtask

  task automatic test_reset();
    goto(700, 9);
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 1'($urandom), 1'b1, 1'b1);
      if ({obs_v, pkt_idx} !== 30'd0) begin
        failures++;
        $display("FAIL reset_state x=%0d got=%h want=0", cx, {obs_v, pkt_idx});
      end
      checks++;
    end
  endtask

  task automatic test_video_line();
    int vpre10 = 0, vde11 = 0, ade_n = 0;
    while (!(cy == 11 && cx == 699)) begin
      step(hs_of(nx()), vs_of(cy), 1'b0, 1'b0);
      if ({obs_v, obs_idx} !== {exp_v, exp_idx}) begin
        failures++; nprint++;
        if (nprint <= 20) $display("FAIL video_line x=%0d y=%0d got=%h want=%h", cx, cy, {obs_v, obs_idx}, {exp_v, exp_idx});
      end
      checks++;
      if (cy == 10 && period == P_VID_PRE) vpre10++;
      if (cy == 11 && VDE) vde11++;
      if (ADE) ade_n++;
    end
    if (vpre10 != 8 || vde11 != H_ACTIVE || ade_n != 0) begin
      failures++;
      $display("FAIL video_counts vid_pre=%0d vde=%0d ade=%0d want 8/640/0", vpre10, vde11, ade_n);
    end
    checks++;
  endtask

  task automatic test_island();
    bit got = 0;
    int rdy_n = 0, rd_n = 0;
    new_payload();
    goto(600, 20);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    while (!(cy == 20 && cx == 720)) begin
      step(hs_of(nx()), 1'b0, (nx() >= ISL_X0) && !got, 1'b0);
      if ({obs_v, obs_idx} !== {exp_v, exp_idx}) begin
        failures++; nprint++;
        if (nprint <= 20) $display("FAIL island x=%0d y=%0d got=%h want=%h", cx, cy, {obs_v, obs_idx}, {exp_v, exp_idx});
      end
      checks++;
      if (pkt_ready) begin got = 1; rdy_n++; end
      if (pkt_rd) rd_n++;
    end
    if (rdy_n != 1 || rd_n != 32) begin
      failures++;
      $display("FAIL island_counts ready=%0d rd=%0d want 1/32", rdy_n, rd_n);
    end
    checks++;
  endtask

  task automatic test_late_valid();
    bit got = 0, pv_on = 0;
    int ade30 = 0, rx = -1, ry = -1;
    new_payload();
    goto(600, 30);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    while (!(cy == 31 && cx == 720)) begin
      if (cy == 30 && nx() == ISL_X0 + 1) pv_on = 1;
      step(hs_of(nx()), 1'b0, pv_on && !got, 1'b0);
      if ({obs_v, obs_idx} !== {exp_v, exp_idx}) begin
        failures++; nprint++;
        if (nprint <= 20) $display("FAIL late_valid x=%0d y=%0d got=%h want=%h", cx, cy, {obs_v, obs_idx}, {exp_v, exp_idx});
      end
      checks++;
      if (cy == 30 && ADE) ade30++;
      if (pkt_ready && !got) begin got = 1; rx = cx; ry = cy; end
    end
    if (ade30 != 0 || rx != ISL_X0 || ry != 31) begin
      failures++;
      $display("FAIL late_valid_start ade30=%0d ready_at=%0d,%0d want 0 and %0d,31", ade30, rx, ry, ISL_X0);
    end
    checks++;
  endtask

  task automatic test_vblank();
    int blank_pre = 0, first524 = -1;
    new_payload();
    goto(700, 478);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    while (!(cy == 0 && cx == 20)) begin
      step(hs_of(nx()), vs_of(cy), ($urandom_range(0, 3) == 0), 1'b0);
      if ({obs_v, obs_idx} !== {exp_v, exp_idx}) begin
        failures++; nprint++;
        if (nprint <= 20) $display("FAIL vblank x=%0d y=%0d got=%h want=%h", cx, cy, {obs_v, obs_idx}, {exp_v, exp_idx});
      end
      checks++;
      if (cy >= 479 && cy <= 523 && period == P_VID_PRE) blank_pre++;
      if (cy == 524 && period == P_VID_PRE && first524 < 0) first524 = cx;
    end
    if (blank_pre != 0 || first524 != VP_X0) begin
      failures++;
      $display("FAIL vblank_preamble blank=%0d first524=%0d want 0 and %0d", blank_pre, first524, VP_X0);
    end
    checks++;
  endtask

  task automatic test_reset_mid_island();
    int rd_after = 0, vpre40 = -1;
    new_payload();
    goto(600, 40);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    while (!(cy == 41 && cx == 100)) begin
      step(hs_of(nx()), 1'b0, 1'b1, (cy == 40 && nx() == 660));
      if ({obs_v, obs_idx} !== {exp_v, exp_idx}) begin
        failures++; nprint++;
        if (nprint <= 20) $display("FAIL reset_island x=%0d y=%0d got=%h want=%h", cx, cy, {obs_v, obs_idx}, {exp_v, exp_idx});
      end
      checks++;
      if (cy == 40 && cx == 660 && (ADE || pkt_rd || period != P_CTRL)) begin
        failures++;
        $display("FAIL reset_abort ade=%0b rd=%0b period=%0d want 0/0/0", ADE, pkt_rd, period);
      end
      if (cy == 40 && cx == 660) checks++;
      if (cy == 40 && cx > 660 && pkt_rd) rd_after++;
      if (cy == 40 && period == P_VID_PRE && vpre40 < 0) vpre40 = cx;
    end
    if (rd_after != 0 || vpre40 != VP_X0) begin
      failures++;
      $display("FAIL reset_recovery rd_after=%0d vid_pre_at=%0d want 0 and %0d", rd_after, vpre40, VP_X0);
    end
    checks++;
  endtask

  task automatic test_sync_island();
    bit got = 0;
    int bad = 0, ade_n = 0;
    new_payload();
    goto(600, 50);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    while (!(cy == 50 && cx == 720)) begin
      step(1'b1, 1'b0, !got, 1'b0);
      if ({obs_v, obs_idx} !== {exp_v, exp_idx}) begin
        failures++; nprint++;
        if (nprint <= 20) $display("FAIL sync_island x=%0d y=%0d got=%h want=%h", cx, cy, {obs_v, obs_idx}, {exp_v, exp_idx});
      end
      checks++;
      if (pkt_ready) got = 1;
      if (ADE) begin ade_n++; if (aux_data_0[1:0] !== 2'b01) bad++; end
    end
    if (bad != 0 || ade_n != 36) begin
      failures++;
      $display("FAIL sync_island_aux bad=%0d ade=%0d want 0/36", bad, ade_n);
    end
    checks++;
  endtask

  task automatic test_random();
    goto(1, 60);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3 * H_TOTAL; i++) begin
      if (cx == 0) new_payload();
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1), 1'b0);
      if ({obs_v, obs_idx} !== {exp_v, exp_idx}) begin
        failures++; nprint++;
        if (nprint <= 20) $display("FAIL random x=%0d y=%0d got=%h want=%h", cx, cy, {obs_v, obs_idx}, {exp_v, exp_idx});
      end
      checks++;
    end
  endtask

  initial begin
    new_payload();
    test_reset();
    test_video_line();
    test_island();
    test_late_valid();
    test_vblank();
    test_reset_mid_island();
    test_sync_island();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
